// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the mips_5_stage store-trace FIFO.
// Latency: n/a (types only).  Backpressure: n/a.
// Contents: TRACE_TS_W default timestamp width, OVF_MAX saturation value,
//           store_rec_t record layout {addr, data, ts}.
package mips_trace_pkg;

  localparam int          TRACE_TS_W = 16;
  localparam logic [15:0] OVF_MAX    = 16'hFFFF;

  typedef struct packed {
    logic [31:0]           addr;
    logic [31:0]           data;
    logic [TRACE_TS_W-1:0] ts;
  } store_rec_t;

endpackage

// File: rtl/mips_trace_fifo_mem.sv
// Record storage: DEPTH x store_rec_t array, one write port, one registered read port.
// Latency: read data valid one clock after raddr_i is presented.
// Backpressure: none here; the owner decides when to write and which entry to read.
// Ports: clk/reset (sync, active-high, clears the read register only),
//        we_i/waddr_i/wdata_i write port, raddr_i read address, rdata_o registered read data.
module mips_trace_fifo_mem
  import mips_trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  store_rec_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output store_rec_t    rdata_o
);

  store_rec_t mem_q [DEPTH];
  store_rec_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Write-first: a record written to the slot being read this edge is
  // forwarded so the read register sees it one clock later, never the stale slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_store_trace_fifo.sv
// Timestamped trace FIFO of mips_5_stage data-memory stores (purely observing).
// Latency: a captured store is on rec_* one clock after its capture edge (registered FWFT).
// Backpressure: rec_valid/rec_ready; when full a store without a same-edge pop is dropped
//   and counted in overflow_cnt (saturating).
// Ports: clk, reset (sync, active-high); memwrite_in/dataadr_in/writedata_in store strobe;
//   rec_valid/rec_ready/rec_addr/rec_data/rec_ts head record; count, full, overflow_cnt status.
// Option: define STORE_FILTER_EN to record only stores with
//   (dataadr_in & FILTER_MASK) == FILTER_BASE; otherwise every store is recorded.
module mips_store_trace_fifo
  import mips_trace_pkg::*;
#(
  parameter  int          DEPTH       = 16,
  parameter  int          TS_W        = TRACE_TS_W,
  parameter  logic [31:0] FILTER_BASE = 32'h0000_0000,
  parameter  logic [31:0] FILTER_MASK = 32'h0000_0000,
  localparam int          PTR_W       = $clog2(DEPTH),
  localparam int          CNT_W       = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite_in,
  input  logic [31:0]      dataadr_in,
  input  logic [31:0]      writedata_in,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [31:0]      rec_addr,
  output logic [31:0]      rec_data,
  output logic [TS_W-1:0]  rec_ts,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic [15:0]      overflow_cnt
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [15:0]      ovf_q,    ovf_d;
  logic [TS_W-1:0]  ts_q;

  logic       filter_hit;
  logic       store_req;
  logic       full_w;
  logic       pop;
  logic       push;
  logic       drop;
  store_rec_t wr_rec;
  store_rec_t head_rec;

`ifdef STORE_FILTER_EN
  assign filter_hit = ((dataadr_in & FILTER_MASK) == FILTER_BASE);
`else
  logic unused_filter;
  assign unused_filter = ^{FILTER_BASE, FILTER_MASK};
  assign filter_hit    = 1'b1;
`endif

  assign store_req = memwrite_in & filter_hit;
  assign full_w    = (count_q == CNT_W'(DEPTH));
  assign pop       = (count_q != '0) & rec_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the store.
  assign push      = store_req & (~full_w | pop);
  assign drop      = store_req & full_w & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop && (ovf_q != OVF_MAX)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      ts_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ts_q     <= ts_q + TS_W'(1);
    end
  end

  always_comb begin
    wr_rec      = '0;
    wr_rec.addr = dataadr_in;
    wr_rec.data = writedata_in;
    wr_rec.ts   = TRACE_TS_W'(ts_q);
  end

  // The read port always looks at the next head, so the registered output
  // already holds the right record after every push/pop edge.
  mips_trace_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push & ~reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_rec),
    .raddr_i (rd_ptr_d),
    .rdata_o (head_rec)
  );

  assign rec_valid    = (count_q != '0);
  assign rec_addr     = head_rec.addr;
  assign rec_data     = head_rec.data;
  assign rec_ts       = TS_W'(head_rec.ts);
  assign count        = count_q;
  assign full         = full_w;
  assign overflow_cnt = ovf_q;

endmodule
